// File: rtl/issue_pkg.sv
// issue_pkg: shared defaults for the issue window.
//   DEF_* : default parameter values for issue_window
//   TAG_ZERO : physical tag of the hard-wired zero register; a source naming
//              it is always ready and never matches a broadcast.
package issue_pkg;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_TAG_W  = 6;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PAY_W  = 128;
  localparam int DEF_NUM_WB = 2;
  localparam int TAG_ZERO   = 0;
endpackage

// File: rtl/oldest_ready_select.sv
// oldest_ready_select: combinational oldest-first picker.
//   cand : per-entry "valid and both sources ready"
//   age  : per-entry age, 0 = oldest; ages of valid entries are unique
//   gnt  : one-hot grant of the candidate with the smallest age
//   idx  : binary index of the granted entry (0 when none)
//   any  : at least one candidate
module oldest_ready_select #(
  parameter int DEPTH = 16,
  parameter int AGE_W = 4,
  parameter int IDX_W = 4
) (
  input  logic [DEPTH-1:0]            cand,
  input  logic [DEPTH-1:0][AGE_W-1:0] age,
  output logic [DEPTH-1:0]            gnt,
  output logic [IDX_W-1:0]            idx,
  output logic                        any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |cand;
    // An entry wins when no other candidate is older; unique ages make it one-hot.
    for (int i = 0; i < DEPTH; i++) begin
      gnt[i] = cand[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && cand[j] && age[j] < age[i]) gnt[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (gnt[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/issue_window.sv
// issue_window: out-of-order issue queue between rename and execute.
//   CLK/RESET(async, active low), STALL, FLUSH
//   enq_*   : rename-side enqueue port (valid/ready) with two source operands
//   wb_*    : NUM_WB result broadcast channels used for operand wakeup
//   iss_*   : registered issue port (valid/ready) towards execute
//   count   : valid entries held (issue register excluded); issue_halt = full
module issue_window
  import issue_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAY_W  = DEF_PAY_W,
  parameter int NUM_WB = DEF_NUM_WB,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     STALL,
  input  logic                     FLUSH,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [TAG_W-1:0]         enq_tag_a,
  input  logic [TAG_W-1:0]         enq_tag_b,
  input  logic                     enq_rdy_a,
  input  logic                     enq_rdy_b,
  input  logic [DATA_W-1:0]        enq_val_a,
  input  logic [DATA_W-1:0]        enq_val_b,
  input  logic [PAY_W-1:0]         enq_payload,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_val,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [DATA_W-1:0]        iss_op_a,
  output logic [DATA_W-1:0]        iss_op_b,
  output logic [PAY_W-1:0]         iss_payload,
  output logic [CNT_W-1:0]         count,
  output logic                     issue_halt
);
  localparam int AGE_W = $clog2(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [TAG_W-1:0] TZ   = TAG_W'(TAG_ZERO);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag_a, tag_b;
    logic              rdy_a, rdy_b;
    logic [DATA_W-1:0] val_a, val_b;
    logic [AGE_W-1:0]  age;
    logic [PAY_W-1:0]  payload;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               iss_valid_q, iss_valid_d;
  logic [DATA_W-1:0]  iss_op_a_q, iss_op_a_d, iss_op_b_q, iss_op_b_d;
  logic [PAY_W-1:0]   iss_pay_q, iss_pay_d;

  logic [DEPTH-1:0]            cand, gnt;
  logic [DEPTH-1:0][AGE_W-1:0] ages;
  logic [IDX_W-1:0]            sel_idx, free_idx;
  logic                        sel_any, enq_fire, deq_fire;
  entry_t                      sel, new_ent;
  logic [DATA_W:0]             hit_a, hit_b;

  // {hit, value} of the lowest-index channel broadcasting tag t.
  function automatic logic [DATA_W:0] wb_lookup(input logic [TAG_W-1:0] t,
      input logic [NUM_WB-1:0] v, input logic [NUM_WB*TAG_W-1:0] tg,
      input logic [NUM_WB*DATA_W-1:0] d);
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_WB - 1; k >= 0; k--)
      if (v[k] && t != TZ && tg[k*TAG_W +: TAG_W] == t) r = {1'b1, d[k*DATA_W +: DATA_W]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = ent_q[i].valid & ent_q[i].rdy_a & ent_q[i].rdy_b;
      ages[i] = ent_q[i].age;
    end
  end

  oldest_ready_select #(.DEPTH(DEPTH), .AGE_W(AGE_W), .IDX_W(IDX_W)) u_sel (
    .cand(cand), .age(ages), .gnt(gnt), .idx(sel_idx), .any(sel_any)
  );

  // Lowest free slot; the slot vacated by this cycle's dequeue is not reused.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
  end

  assign sel       = ent_q[sel_idx];
  assign enq_ready = !STALL && (count_q < FULL);
  assign enq_fire  = enq_valid && enq_ready && !FLUSH;
  assign deq_fire  = !STALL && !FLUSH && sel_any && (!iss_valid_q || iss_ready);

  // Incoming entry, including same-cycle broadcast capture.
  always_comb begin
    hit_a           = wb_lookup(enq_tag_a, wb_valid, wb_tag, wb_val);
    hit_b           = wb_lookup(enq_tag_b, wb_valid, wb_tag, wb_val);
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.tag_a   = enq_tag_a;
    new_ent.tag_b   = enq_tag_b;
    new_ent.rdy_a   = (enq_tag_a == TZ) || enq_rdy_a || hit_a[DATA_W];
    new_ent.rdy_b   = (enq_tag_b == TZ) || enq_rdy_b || hit_b[DATA_W];
    new_ent.val_a   = hit_a[DATA_W] ? hit_a[DATA_W-1:0] : enq_val_a;
    new_ent.val_b   = hit_b[DATA_W] ? hit_b[DATA_W-1:0] : enq_val_b;
    new_ent.age     = AGE_W'(count_q) - AGE_W'(deq_fire);
    new_ent.payload = enq_payload;
  end

  always_comb begin
    logic [DATA_W:0] h;
    ent_d   = ent_q;
    count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    for (int i = 0; i < DEPTH; i++) begin
      // Wakeup runs regardless of STALL.
      h = wb_lookup(ent_q[i].tag_a, wb_valid, wb_tag, wb_val);
      if (ent_q[i].valid && !ent_q[i].rdy_a && h[DATA_W]) begin
        ent_d[i].rdy_a = 1'b1;
        ent_d[i].val_a = h[DATA_W-1:0];
      end
      h = wb_lookup(ent_q[i].tag_b, wb_valid, wb_tag, wb_val);
      if (ent_q[i].valid && !ent_q[i].rdy_b && h[DATA_W]) begin
        ent_d[i].rdy_b = 1'b1;
        ent_d[i].val_b = h[DATA_W-1:0];
      end
      // Entries younger than the departing one close the age gap.
      if (deq_fire) begin
        if (gnt[i]) ent_d[i].valid = 1'b0;
        else if (ent_q[i].valid && ent_q[i].age > sel.age) ent_d[i].age = ent_q[i].age - 1'b1;
      end
    end
    if (enq_fire) ent_d[free_idx] = new_ent;
    if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      count_d = '0;
    end
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_op_a_d  = iss_op_a_q;
    iss_op_b_d  = iss_op_b_q;
    iss_pay_d   = iss_pay_q;
    if (FLUSH) iss_valid_d = 1'b0;
    else if (deq_fire) begin
      iss_valid_d = 1'b1;
      iss_op_a_d  = sel.val_a;
      iss_op_b_d  = sel.val_b;
      iss_pay_d   = sel.payload;
    end else if (!STALL && iss_ready) iss_valid_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ent_q       <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_op_a_q  <= '0;
      iss_op_b_q  <= '0;
      iss_pay_q   <= '0;
    end else begin
      ent_q       <= ent_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_op_a_q  <= iss_op_a_d;
      iss_op_b_q  <= iss_op_b_d;
      iss_pay_q   <= iss_pay_d;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_op_a    = iss_op_a_q;
  assign iss_op_b    = iss_op_b_q;
  assign iss_payload = iss_pay_q;
  assign count       = count_q;
  assign issue_halt  = (count_q == FULL);
endmodule

// File: tb/tb_issue_window.sv
// tb_issue_window: directed bench for issue_window at default parameters.
module tb_issue_window;
  logic         CLK = 1'b0, RESET = 1'b0, STALL = 1'b0, FLUSH = 1'b0;
  logic         enq_valid = 1'b0, enq_ready;
  logic [5:0]   enq_tag_a = '0, enq_tag_b = '0;
  logic         enq_rdy_a = 1'b0, enq_rdy_b = 1'b0;
  logic [31:0]  enq_val_a = '0, enq_val_b = '0;
  logic [127:0] enq_payload = '0;
  logic [1:0]   wb_valid = '0;
  logic [11:0]  wb_tag = '0;
  logic [63:0]  wb_val = '0;
  logic         iss_valid, iss_ready = 1'b1;
  logic [31:0]  iss_op_a, iss_op_b;
  logic [127:0] iss_payload;
  logic [4:0]   count;
  logic         issue_halt;
  int           passes = 0, total = 0;

  issue_window dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_tag_a(enq_tag_a), .enq_tag_b(enq_tag_b),
    .enq_rdy_a(enq_rdy_a), .enq_rdy_b(enq_rdy_b),
    .enq_val_a(enq_val_a), .enq_val_b(enq_val_b), .enq_payload(enq_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op_a(iss_op_a), .iss_op_b(iss_op_b), .iss_payload(iss_payload),
    .count(count), .issue_halt(issue_halt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic enq(input logic [5:0] ta, input logic ra, input logic [31:0] va,
                     input logic [5:0] tb, input logic rb, input logic [31:0] vb,
                     input logic [127:0] pay);
    enq_valid = 1'b1; enq_tag_a = ta; enq_rdy_a = ra; enq_val_a = va;
    enq_tag_b = tb; enq_rdy_b = rb; enq_val_b = vb; enq_payload = pay;
  endtask

  task automatic wb(input logic [1:0] v, input logic [5:0] t0, input logic [31:0] d0,
                    input logic [5:0] t1, input logic [31:0] d1);
    wb_valid = v; wb_tag = {t1, t0}; wb_val = {d1, d0};
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_op_a", iss_op_a, 0);
    chk("rst_op_b", iss_op_b, 0);
    chk("rst_payload", iss_payload, 0);
    chk("rst_halt", issue_halt, 0);
    chk("rst_enq_ready", enq_ready, 1);
    STALL = 1'b1; #1;
    chk("rst_enq_ready_stall", enq_ready, 0);
    STALL = 1'b0;
    RESET = 1'b1;
    step();

    // Both sources on tag 0: in the queue after one edge, issued after the next
    enq(0, 0, 5, 0, 0, 7, 128'h111);
    step(); enq_valid = 1'b0;
    chk("t1_count", count, 1);
    chk("t1_not_yet", iss_valid, 0);
    step();
    chk("t1_iss_valid", iss_valid, 1);
    chk("t1_op_a", iss_op_a, 5);
    chk("t1_op_b", iss_op_b, 7);
    chk("t1_payload", iss_payload, 128'h111);
    chk("t1_count_after", count, 0);
    step();
    chk("t1_drained", iss_valid, 0);

    // Younger ready entry B bypasses older waiting A
    enq(9, 0, 0, 0, 0, 2, 128'hA);
    step();
    enq(0, 0, 3, 0, 0, 4, 128'hB);
    step(); enq_valid = 1'b0;
    chk("t2_count", count, 2);
    wb(2'b10, 0, 0, 9, 32'hDEAD);
    step(); wb(0, 0, 0, 0, 0);
    chk("t2_first_B", iss_payload, 128'hB);
    chk("t2_count1", count, 1);
    step();
    chk("t2_then_A", iss_payload, 128'hA);
    chk("t2_A_op_a", iss_op_a, 32'hDEAD);
    chk("t2_A_op_b", iss_op_b, 2);
    step();
    chk("t2_drained", iss_valid, 0);

    // Same-cycle bypass; both channels match, channel 0 wins
    enq(0, 0, 1, 12, 0, 32'hFF, 128'hC);
    wb(2'b11, 12, 3, 12, 32'h99);
    step(); enq_valid = 1'b0; wb(0, 0, 0, 0, 0);
    chk("t3_count", count, 1);
    step();
    chk("t3_iss_valid", iss_valid, 1);
    chk("t3_op_a", iss_op_a, 1);
    chk("t3_op_b_bypass", iss_op_b, 3);
    step();

    // Fill to capacity with waiting entries
    for (int i = 0; i < 16; i++) begin
      enq(6'(i + 1), 0, 0, 0, 0, 32'(i), 128'(i));
      step();
    end
    enq(0, 0, 1, 0, 0, 1, 128'h77);
    #1;
    chk("t4_count_full", count, 16);
    chk("t4_halt", issue_halt, 1);
    chk("t4_enq_ready_full", enq_ready, 0);
    step();
    chk("t4_no_overfill", count, 16);
    // Wake everyone youngest-first while stalled; no issue may occur
    STALL = 1'b1; enq_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      wb(2'b11, 6'(16 - 2 * j), 32'h100, 6'(15 - 2 * j), 32'h100);
      step();
    end
    wb(0, 0, 0, 0, 0);
    chk("t4_stall_no_issue", iss_valid, 0);
    chk("t4_stall_count", count, 16);
    STALL = 1'b0;
    enq(0, 0, 1, 0, 0, 1, 128'h77);
    #1;
    chk("t4_full_no_reuse", enq_ready, 0);
    step(); enq_valid = 1'b0;
    chk("t4_iss_0", iss_payload, 0);
    chk("t4_op_a_woken", iss_op_a, 32'h100);
    chk("t4_count15", count, 15);
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("t4_iss_%0d", i), iss_payload, 128'(i));
      chk($sformatf("t4_op_b_%0d", i), iss_op_b, 32'(i));
    end
    step();
    chk("t4_drained", iss_valid, 0);
    chk("t4_empty", count, 0);

    // Execute back-pressure with STALL and broadcasts
    iss_ready = 1'b0;
    enq(0, 0, 10, 0, 0, 11, 128'h51);
    step();
    enq(30, 0, 0, 31, 0, 0, 128'h52);
    step(); enq_valid = 1'b0;
    chk("t5_iss_X", iss_payload, 128'h51);
    STALL = 1'b1;
    wb(2'b01, 30, 32'h300, 0, 0);
    step();
    chk("t5_hold_valid", iss_valid, 1);
    chk("t5_hold_op_a", iss_op_a, 10);
    wb(2'b10, 0, 0, 31, 32'h310); iss_ready = 1'b1;
    step();
    chk("t5_stall_hold", iss_payload, 128'h51);
    chk("t5_stall_valid", iss_valid, 1);
    STALL = 1'b0; wb(0, 0, 0, 0, 0);
    step();
    chk("t5_iss_Y", iss_payload, 128'h52);
    chk("t5_Y_op_a", iss_op_a, 32'h300);
    chk("t5_Y_op_b", iss_op_b, 32'h310);
    step();
    chk("t5_drained", iss_valid, 0);

    // FLUSH with 5 queued and a held issue register
    iss_ready = 1'b0;
    enq(0, 0, 1, 0, 0, 1, 128'h60);
    step();
    for (int i = 0; i < 5; i++) begin
      enq(40, 0, 0, 0, 0, 0, 128'(32'h70 + i));
      step();
    end
    chk("t6_count5", count, 5);
    chk("t6_iss_valid", iss_valid, 1);
    enq(0, 0, 1, 0, 0, 1, 128'h99);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0; enq_valid = 1'b0; iss_ready = 1'b1;
    chk("t6_flush_count", count, 0);
    chk("t6_flush_iss", iss_valid, 0);
    step();
    chk("t6_enq_discarded", iss_valid, 0);
    chk("t6_still_empty", count, 0);

    // Asynchronous reset mid-operation
    enq(50, 0, 0, 0, 0, 0, 128'h88);
    step(); enq_valid = 1'b0;
    chk("t7_count1", count, 1);
    #2 RESET = 1'b0; #1;
    chk("t7_async_count", count, 0);
    chk("t7_async_halt", issue_halt, 0);
    RESET = 1'b1;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
